// File: rtl/rvj1_irq_pkg.sv
// Shared definitions for the rvj1 interrupt controller: register map, source limit, claim ID type.
package rvj1_irq_pkg;

  localparam int unsigned MAX_SRC    = 31;
  localparam int unsigned CLAIM_ID_W = $clog2(MAX_SRC + 1);

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_MODE    = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  typedef logic [CLAIM_ID_W-1:0] claim_id_t;

endpackage

// File: rtl/rvj1_irq_if.sv
// Word-addressed register port between the SoC data bus and the interrupt controller.
interface rvj1_irq_if;

  logic        reg_req_i;
  logic        reg_we_i;
  logic [1:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        reg_ack_o;

  modport master (
    output reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i,
    input  reg_rdata_o, reg_ack_o
  );

  modport slave (
    input  reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i,
    output reg_rdata_o, reg_ack_o
  );

endinterface

// File: rtl/rvj1_irq_edge_det.sv
// Optional synchronizer chain plus previous-value flop; exposes the synchronized lines and rise pulses.
module rvj1_irq_edge_det #(
  parameter int unsigned W      = 8,
  parameter int unsigned STAGES = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] s_c,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] prev_q;

  if (STAGES == 0) begin : g_nosync
    assign s_c = d_i;
  end else begin : g_sync
    logic [W-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int k = 0; k < int'(STAGES); k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= d_i;
        for (int k = 1; k < int'(STAGES); k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s_c = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= s_c;
  end

  assign rise_c = s_c & ~prev_q;

endmodule

// File: rtl/rvj1_irq_ctrl.sv
// Interrupt controller: latches timer/peripheral IRQs, applies enable and edge/level mode,
// fixed lowest-index priority claim, single level interrupt to the core.
module rvj1_irq_ctrl
  import rvj1_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  rvj1_irq_if.slave          bus,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] s_c, rise_c;
  logic [NUM_SRC-1:0] pending_q, enable_q, mode_q;
  logic [NUM_SRC-1:0] pend_nxt_c, active_c, claim_oh_c, clr_c, mode_chg_c, wmask_c;
  claim_id_t          claim_id_c;
  logic               wr_pend_c, wr_en_c, wr_mode_c, rd_claim_c;
  logic [31:0]        rd_mux_c;
  logic               unused_wdata_c;

  rvj1_irq_edge_det #(
    .W      (NUM_SRC),
    .STAGES (SYNC_STAGES)
  ) u_edge_det (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (irq_src_i),
    .s_c    (s_c),
    .rise_c (rise_c)
  );

  assign wmask_c        = bus.reg_wdata_i[NUM_SRC-1:0];
  assign unused_wdata_c = ^bus.reg_wdata_i[31:NUM_SRC];

  assign wr_pend_c  = bus.reg_req_i &  bus.reg_we_i & (bus.reg_addr_i == REG_PENDING);
  assign wr_en_c    = bus.reg_req_i &  bus.reg_we_i & (bus.reg_addr_i == REG_ENABLE);
  assign wr_mode_c  = bus.reg_req_i &  bus.reg_we_i & (bus.reg_addr_i == REG_MODE);
  assign rd_claim_c = bus.reg_req_i & ~bus.reg_we_i & (bus.reg_addr_i == REG_CLAIM);

  // Lowest-index active source: one-hot for clearing, ID+1 for the CLAIM read.
  always_comb begin
    active_c   = pending_q & enable_q;
    claim_oh_c = active_c & (~active_c + NUM_SRC'(1));
    claim_id_c = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active_c[i]) claim_id_c = claim_id_t'(i + 1);
    end
  end

  // Edge bits: sticky with W1C/claim clear, a new rise wins. Level bits track s.
  always_comb begin
    clr_c      = '0;
    mode_chg_c = '0;
    if (wr_pend_c)  clr_c = wmask_c;
    if (rd_claim_c) clr_c = claim_oh_c;
    if (wr_mode_c)  mode_chg_c = mode_q ^ wmask_c;
    pend_nxt_c = (mode_q & ((pending_q & ~clr_c) | rise_c)) | (~mode_q & s_c);
    pend_nxt_c = pend_nxt_c & ~mode_chg_c;
  end

  always_comb begin
    rd_mux_c = '0;
    case (bus.reg_addr_i)
      REG_PENDING: rd_mux_c = 32'(pending_q);
      REG_ENABLE:  rd_mux_c = 32'(enable_q);
      REG_MODE:    rd_mux_c = 32'(mode_q);
      REG_CLAIM:   rd_mux_c = 32'(claim_id_c);
      default:     rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q       <= '0;
      enable_q        <= '0;
      mode_q          <= '0;
      irq_o           <= 1'b0;
      bus.reg_ack_o   <= 1'b0;
      bus.reg_rdata_o <= '0;
    end else begin
      pending_q       <= pend_nxt_c;
      if (wr_en_c)   enable_q <= wmask_c;
      if (wr_mode_c) mode_q   <= wmask_c;
      irq_o           <= |active_c;
      bus.reg_ack_o   <= bus.reg_req_i;
      bus.reg_rdata_o <= (bus.reg_req_i & ~bus.reg_we_i) ? rd_mux_c : '0;
    end
  end

endmodule
